hash_table_requester: RTL and testbench

//  Initiator for the hash-table command/response stream. Packs host commands {op,key,data} into

---
 rtl/hash_table_pkg.sv | 72 +++++++
 rtl/hash_req_tracker_fifo.sv | 46 ++++
 rtl/hash_table_requester.sv | 157 +++++++++++++++
 tb/tb_hash_table_requester.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared definitions for the hash-table requester: op codes, result status codes,
// response flag positions and the request word packer.
package hash_table_pkg;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_DELETE  = 2'b11;

  typedef enum logic [2:0] {
    ST_OK            = 3'd0,
    ST_KEY_PRESENT   = 3'd1,
    ST_NOT_FOUND     = 3'd2,
    ST_TABLE_FULL    = 3'd3,
    ST_NO_DEL_TARGET = 3'd4,
    ST_PROTO_ERR     = 3'd5
  } status_t;

  // Flag positions are counted down from the response word MSB (1 = MSB).
  localparam int FLAG_KEY_PRESENT_OFS   = 1;
  localparam int FLAG_NOT_FOUND_OFS     = 2;
  localparam int FLAG_NO_SPACE_OFS      = 3;
  localparam int FLAG_NO_DEL_TARGET_OFS = 4;

  localparam int PACK_MAX_KEY  = 32;
  localparam int PACK_MAX_DATA = 64;
  localparam int PACK_MAX_WORD = 128;

  typedef struct packed {
    logic key_present;
    logic not_found;
    logic no_space;
    logic no_del_target;
  } rsp_flags_t;

  // Width-generic packer: the caller truncates the result to its real word width.
  function automatic logic [PACK_MAX_WORD-1:0] pack_req(
    input logic [1:0]               op,
    input logic [PACK_MAX_KEY-1:0]  key,
    input logic [PACK_MAX_DATA-1:0] data,
    input int unsigned              key_w,
    input int unsigned              data_w
  );
    logic [PACK_MAX_WORD-1:0] word;
    word = PACK_MAX_WORD'(op) << (key_w + data_w);
    word = word | (PACK_MAX_WORD'(key) << data_w);
    word = word | PACK_MAX_WORD'(data);
    return word;
  endfunction

  function automatic status_t decode_status(input logic [1:0] op, input rsp_flags_t flags);
    status_t    status;
    logic [2:0] n_set;
    n_set  = 3'(flags.key_present) + 3'(flags.not_found) +
             3'(flags.no_space) + 3'(flags.no_del_target);
    status = ST_PROTO_ERR;
    if (n_set == 3'd0) begin
      status = ST_OK;
    end else if (n_set == 3'd1) begin
      if (op == OP_READ && flags.not_found)
        status = ST_NOT_FOUND;
      else if (op == OP_WRITE && flags.key_present)
        status = ST_KEY_PRESENT;
      else if (op == OP_WRITE && flags.no_space)
        status = ST_TABLE_FULL;
      else if (op == OP_DELETE && flags.no_del_target)
        status = ST_NO_DEL_TARGET;
    end
    return status;
  endfunction

endpackage

// File: rtl/hash_req_tracker_fifo.sv
// In-order tracker of outstanding commands: synchronous FIFO with wrap-bit pointers,
// accepting a push and a pop in the same cycle even when full.
module hash_req_tracker_fifo #(
  parameter int ENTRY_WIDTH = 7,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] push_entry,
  input  logic                   pop,
  output logic [ENTRY_WIDTH-1:0] head,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hash_table_requester.sv
// Hash-table command initiator: registers host commands onto the request stream, tracks
// them in order, and turns each response into a status result with the original op/key.
module hash_table_requester
  import hash_table_pkg::*;
#(
  parameter  int KEY_WIDTH       = 4,
  parameter  int DATA_WIDTH      = 26,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_WIDTH       = 16,
  localparam int W               = 2 + DATA_WIDTH + KEY_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic [1:0]            host_op_i,
  input  logic [KEY_WIDTH-1:0]  host_key_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [W-1:0]          req_data_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [W-1:0]          rsp_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [2:0]            res_status_o,
  output logic [1:0]            res_op_o,
  output logic [KEY_WIDTH-1:0]  res_key_o,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic [CNT_WIDTH-1:0]  issued_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  orphan_o
);

  typedef struct packed {
    logic                 is_local;
    logic [1:0]           op;
    logic [KEY_WIDTH-1:0] key;
  } entry_t;

  entry_t                push_entry;
  entry_t                head;
  logic                  full;
  logic                  empty;
  logic                  host_fire;
  logic                  host_legal;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  orphan_fire;
  logic                  can_load;
  logic                  res_load;
  logic [W-1:0]          req_word;
  logic [DATA_WIDTH-1:0] data_eff;
  rsp_flags_t            flags;
  status_t               next_status;
  logic [DATA_WIDTH-1:0] next_data;
  logic [1:0]            err_inc;
  logic                  rsp_unused;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  assign host_ready_o = !full && (!req_valid_o || req_ready_i);
  assign host_fire    = host_valid_i && host_ready_o;
  assign host_legal   = (host_op_i != OP_ILLEGAL);
  assign req_fire     = req_valid_o && req_ready_i;
  assign can_load     = !res_valid_o || res_ready_i;

  // A local (illegal-op) head owns the result slot, so responses wait behind it.
  assign rsp_ready_o  = empty ? 1'b1 : (can_load && !head.is_local);
  assign rsp_fire     = rsp_valid_i && rsp_ready_o;
  assign orphan_fire  = rsp_fire && empty;
  assign res_load     = !empty && can_load && (head.is_local || rsp_valid_i);

  assign data_eff   = (host_op_i == OP_WRITE) ? host_data_i : '0;
  assign req_word   = W'(pack_req(host_op_i, PACK_MAX_KEY'(host_key_i), PACK_MAX_DATA'(data_eff),
                                  KEY_WIDTH, DATA_WIDTH));
  assign push_entry = '{is_local: !host_legal, op: host_op_i, key: host_key_i};

  assign flags = '{key_present:   rsp_data_i[W-FLAG_KEY_PRESENT_OFS],
                   not_found:     rsp_data_i[W-FLAG_NOT_FOUND_OFS],
                   no_space:      rsp_data_i[W-FLAG_NO_SPACE_OFS],
                   no_del_target: rsp_data_i[W-FLAG_NO_DEL_TARGET_OFS]};
  assign rsp_unused = ^rsp_data_i[W-5:DATA_WIDTH];

  always_comb begin
    next_status = head.is_local ? ST_PROTO_ERR : decode_status(head.op, flags);
    next_data   = '0;
    if (!head.is_local && next_status == ST_OK && head.op == OP_READ)
      next_data = rsp_data_i[DATA_WIDTH-1:0];
  end

  assign err_inc = 2'(res_load && (next_status != ST_OK)) + 2'(orphan_fire);

  hash_req_tracker_fifo #(
    .ENTRY_WIDTH ($bits(entry_t)),
    .DEPTH       (MAX_OUTSTANDING)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (reset),
    .push       (host_fire),
    .push_entry (push_entry),
    .pop        (res_load),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Illegal ops are tracked but never reach the table stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid_o <= 1'b0;
      req_data_o  <= '0;
    end else if (host_fire && host_legal) begin
      req_valid_o <= 1'b1;
      req_data_o  <= req_word;
    end else if (req_fire) begin
      req_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_o  <= 1'b0;
      res_status_o <= '0;
      res_op_o     <= '0;
      res_key_o    <= '0;
      res_data_o   <= '0;
    end else if (res_load) begin
      res_valid_o  <= 1'b1;
      res_status_o <= next_status;
      res_op_o     <= head.op;
      res_key_o    <= head.key;
      res_data_o   <= next_data;
    end else if (res_ready_i) begin
      res_valid_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_cnt_o <= '0;
      err_cnt_o    <= '0;
      orphan_o     <= 1'b0;
    end else begin
      issued_cnt_o <= sat_add(issued_cnt_o, {1'b0, req_fire});
      err_cnt_o    <= sat_add(err_cnt_o, err_inc);
      if (orphan_fire) orphan_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hash_table_requester.sv
// Scenario bench for hash_table_requester: expected requests/results are queued when
// stimulus is driven and popped as the DUT produces them.
module tb_hash_table_requester;
  import hash_table_pkg::*;

  localparam int KW = 4;
  localparam int DW = 26;
  localparam int W  = 2 + DW + KW;
  localparam int CW = 16;

  typedef struct packed {
    logic [2:0]    st;
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [DW-1:0] data;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_valid_i, host_ready_o;
  logic [1:0]    host_op_i;
  logic [KW-1:0] host_key_i;
  logic [DW-1:0] host_data_i;
  logic          req_valid_o, req_ready_i;
  logic [W-1:0]  req_data_o;
  logic          rsp_valid_i, rsp_ready_o;
  logic [W-1:0]  rsp_data_i;
  logic          res_valid_o, res_ready_i;
  logic [2:0]    res_status_o;
  logic [1:0]    res_op_o;
  logic [KW-1:0] res_key_o;
  logic [DW-1:0] res_data_o;
  logic [CW-1:0] issued_cnt_o, err_cnt_o;
  logic          orphan_o;

  int checks = 0;
  int errors = 0;
  int exp_issued = 0;
  int exp_err = 0;
  logic [W-1:0] req_q[$];
  res_t         res_q[$];

  hash_table_requester dut (
    .clk(clk), .reset(reset),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_op_i(host_op_i),
    .host_key_i(host_key_i), .host_data_i(host_data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_data_o(req_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_status_o(res_status_o),
    .res_op_o(res_op_o), .res_key_o(res_key_o), .res_data_o(res_data_o),
    .issued_cnt_o(issued_cnt_o), .err_cnt_o(err_cnt_o), .orphan_o(orphan_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_req(input logic [1:0] op, input logic [KW-1:0] key,
                                          input logic [DW-1:0] data);
    logic [DW-1:0] d;
    d = (op == OP_WRITE) ? data : '0;
    return {op, key, d};
  endfunction

  function automatic res_t mk_res(input status_t st, input logic [1:0] op,
                                  input logic [KW-1:0] key, input logic [DW-1:0] data);
    res_t r;
    r.st = st; r.op = op; r.key = key; r.data = data;
    return r;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [KW-1:0] key,
                       input logic [DW-1:0] data, output bit ok);
    ok = 1'b0;
    host_valid_i = 1'b1; host_op_i = op; host_key_i = key; host_data_i = data;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (host_ready_o) ok = 1'b1;
      step();
    end
    host_valid_i = 1'b0;
  endtask

  task automatic get_req(output logic [W-1:0] word, output bit ok);
    ok = 1'b0; word = '0; req_ready_i = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (req_valid_o) begin ok = 1'b1; word = req_data_o; end
      step();
    end
    req_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [W-1:0] word, output bit ok);
    ok = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = word;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (rsp_ready_o) ok = 1'b1;
      step();
    end
    rsp_valid_i = 1'b0;
  endtask

  task automatic get_res(output res_t r, output bit ok);
    ok = 1'b0; r = '0; res_ready_i = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (res_valid_o) begin
        ok = 1'b1;
        r  = {res_status_o, res_op_o, res_key_o, res_data_o};
      end
      step();
    end
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++;
    if (req_valid_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valids: req_valid=%b res_valid=%b expected 0 0", req_valid_o, res_valid_o);
    end
    checks++;
    if (issued_cnt_o !== '0 || err_cnt_o !== '0 || orphan_o !== 1'b0 || req_data_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: issued=%0d err=%0d orphan=%b req_data=%h expected 0", issued_cnt_o, err_cnt_o, orphan_o, req_data_o);
    end
    reset = 1'b1;
    step();
    checks++;
    if (host_ready_o !== 1'b1 || rsp_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: host_ready=%b rsp_ready=%b expected 1 1", host_ready_o, rsp_ready_o);
    end
  endtask

  task automatic test_write_ok();
    bit ok; logic [W-1:0] word, exp_w; res_t got, exp_r;
    req_q.push_back(32'h8C000155);
    res_q.push_back(mk_res(ST_OK, OP_WRITE, 4'd3, '0));
    issue(OP_WRITE, 4'd3, 26'h155, ok);
    checks++;
    if (!ok || req_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_latency: accepted=%b req_valid=%b expected 1 1", ok, req_valid_o);
    end
    get_req(word, ok);
    exp_issued++;
    exp_w = req_q.pop_front();
    checks++;
    if (!ok || word !== exp_w) begin
      errors++;
      $display("[TB] FAIL write_req: got %h expected %h (seen=%b)", word, exp_w, ok);
    end
    respond(32'h0, ok);
    get_res(got, ok);
    exp_r = res_q.pop_front();
    checks++;
    if (!ok || got !== exp_r) begin
      errors++;
      $display("[TB] FAIL write_res: got %h expected %h (seen=%b)", got, exp_r, ok);
    end
    checks++;
    if (issued_cnt_o !== CW'(exp_issued) || err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL write_cnt: issued=%0d err=%0d expected %0d %0d", issued_cnt_o, err_cnt_o, exp_issued, exp_err);
    end
  endtask

  task automatic test_read();
    bit ok; logic [W-1:0] word, exp_w; res_t got, exp_r;
    logic [W-1:0] rsps [2];
    rsps[0] = 32'h40000000;
    rsps[1] = 32'h0C000ABC;
    res_q.push_back(mk_res(ST_NOT_FOUND, OP_READ, 4'd5, '0));
    res_q.push_back(mk_res(ST_OK, OP_READ, 4'd5, 26'hABC));
    exp_err++;
    for (int i = 0; i < 2; i++) begin
      req_q.push_back(32'h54000000);
      issue(OP_READ, 4'd5, 26'h3FFFFFF, ok);
      get_req(word, ok);
      exp_issued++;
      exp_w = req_q.pop_front();
      checks++;
      if (!ok || word !== exp_w) begin
        errors++;
        $display("[TB] FAIL read_req%0d: got %h expected %h (seen=%b)", i, word, exp_w, ok);
      end
      respond(rsps[i], ok);
      get_res(got, ok);
      exp_r = res_q.pop_front();
      checks++;
      if (!ok || got !== exp_r) begin
        errors++;
        $display("[TB] FAIL read_res%0d: got %h expected %h (seen=%b)", i, got, exp_r, ok);
      end
    end
    checks++;
    if (err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL read_err_cnt: got %0d expected %0d", err_cnt_o, exp_err);
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable; logic [W-1:0] word, exp_w; res_t got, exp_r;
    req_q.push_back(mk_req(OP_WRITE, 4'd2, 26'h7));
    res_q.push_back(mk_res(ST_KEY_PRESENT, OP_WRITE, 4'd2, '0));
    exp_err++;
    req_ready_i = 1'b0;
    issue(OP_WRITE, 4'd2, 26'h7, ok);
    stable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (req_valid_o !== 1'b1 || req_data_o !== req_q[0] || host_ready_o !== 1'b0) stable = 1'b0;
      step();
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL hold_stable: req_valid=%b data=%h host_ready=%b expected 1 %h 0", req_valid_o, req_data_o, host_ready_o, req_q[0]);
    end
    get_req(word, ok);
    exp_issued++;
    exp_w = req_q.pop_front();
    checks++;
    if (!ok || word !== exp_w) begin
      errors++;
      $display("[TB] FAIL hold_req: got %h expected %h (seen=%b)", word, exp_w, ok);
    end
    respond(32'h80000000, ok);
    get_res(got, ok);
    exp_r = res_q.pop_front();
    checks++;
    if (!ok || got !== exp_r) begin
      errors++;
      $display("[TB] FAIL key_present_res: got %h expected %h (seen=%b)", got, exp_r, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [W-1:0] exp_w; res_t got, exp_r;
    logic [1:0]   ops  [4];
    logic [W-1:0] rsps [4];
    status_t      sts  [4];
    ops[0] = OP_WRITE;  rsps[0] = 32'h00000000; sts[0] = ST_OK;
    ops[1] = OP_READ;   rsps[1] = 32'h40000000; sts[1] = ST_NOT_FOUND;
    ops[2] = OP_DELETE; rsps[2] = 32'h10000000; sts[2] = ST_NO_DEL_TARGET;
    ops[3] = OP_WRITE;  rsps[3] = 32'h20000000; sts[3] = ST_TABLE_FULL;
    req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(mk_req(ops[i], KW'(i + 1), DW'(11 * (i + 1))));
      res_q.push_back(mk_res(sts[i], ops[i], KW'(i + 1), '0));
      issue(ops[i], KW'(i + 1), DW'(11 * (i + 1)), ok);
      exp_w = req_q.pop_front();
      checks++;
      if (!ok || req_valid_o !== 1'b1 || req_data_o !== exp_w) begin
        errors++;
        $display("[TB] FAIL b2b_req%0d: valid=%b data=%h expected 1 %h (accepted=%b)", i, req_valid_o, req_data_o, exp_w, ok);
      end
    end
    checks++;
    if (host_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tracker_full: host_ready=%b expected 0", host_ready_o);
    end
    step();
    req_ready_i = 1'b0;
    exp_issued += 4;
    exp_err += 3;
    for (int i = 0; i < 4; i++) begin
      respond(rsps[i], ok);
      get_res(got, ok);
      exp_r = res_q.pop_front();
      checks++;
      if (!ok || got !== exp_r) begin
        errors++;
        $display("[TB] FAIL order_res%0d: got %h expected %h (seen=%b)", i, got, exp_r, ok);
      end
    end
    checks++;
    if (host_ready_o !== 1'b1 || issued_cnt_o !== CW'(exp_issued) || err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL b2b_cnt: host_ready=%b issued=%0d err=%0d expected 1 %0d %0d", host_ready_o, issued_cnt_o, err_cnt_o, exp_issued, exp_err);
    end
  endtask

  task automatic test_proto_err();
    bit ok; logic [W-1:0] word; res_t got, exp_r;
    logic [1:0]   ops  [2];
    logic [W-1:0] rsps [2];
    ops[0] = OP_WRITE;  rsps[0] = 32'h10000000;
    ops[1] = OP_DELETE; rsps[1] = 32'h50000000;
    for (int i = 0; i < 2; i++) begin
      res_q.push_back(mk_res(ST_PROTO_ERR, ops[i], KW'(7 + i), '0));
      issue(ops[i], KW'(7 + i), 26'h1, ok);
      get_req(word, ok);
      exp_issued++;
      exp_err++;
      respond(rsps[i], ok);
      get_res(got, ok);
      exp_r = res_q.pop_front();
      checks++;
      if (!ok || got !== exp_r) begin
        errors++;
        $display("[TB] FAIL proto_res%0d: got %h expected %h (seen=%b)", i, got, exp_r, ok);
      end
    end
    checks++;
    if (err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL proto_err_cnt: got %0d expected %0d", err_cnt_o, exp_err);
    end
  endtask

  task automatic test_illegal_op();
    bit ok; logic [W-1:0] word, exp_w; res_t got, exp_r;
    req_q.push_back(mk_req(OP_WRITE, 4'd6, 26'h2A));
    res_q.push_back(mk_res(ST_OK, OP_WRITE, 4'd6, '0));
    res_q.push_back(mk_res(ST_PROTO_ERR, OP_ILLEGAL, 4'd9, '0));
    issue(OP_WRITE, 4'd6, 26'h2A, ok);
    get_req(word, ok);
    exp_issued++;
    exp_w = req_q.pop_front();
    checks++;
    if (!ok || word !== exp_w) begin
      errors++;
      $display("[TB] FAIL illegal_prev_req: got %h expected %h (seen=%b)", word, exp_w, ok);
    end
    issue(OP_ILLEGAL, 4'd9, 26'h5, ok);
    checks++;
    if (!ok || req_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_not_sent: accepted=%b req_valid=%b expected 1 0", ok, req_valid_o);
    end
    step(3);
    checks++;
    if (res_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_in_order: res_valid=%b expected 0 before head response", res_valid_o);
    end
    respond(32'h0, ok);
    exp_err++;
    for (int i = 0; i < 2; i++) begin
      get_res(got, ok);
      exp_r = res_q.pop_front();
      checks++;
      if (!ok || got !== exp_r) begin
        errors++;
        $display("[TB] FAIL illegal_res%0d: got %h expected %h (seen=%b)", i, got, exp_r, ok);
      end
    end
    checks++;
    if (issued_cnt_o !== CW'(exp_issued) || err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL illegal_cnt: issued=%0d err=%0d expected %0d %0d", issued_cnt_o, err_cnt_o, exp_issued, exp_err);
    end
  endtask

  task automatic test_orphan();
    bit ok;
    respond(32'h00000123, ok);
    exp_err++;
    checks++;
    if (!ok || orphan_o !== 1'b1 || res_valid_o !== 1'b0 || err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL orphan: accepted=%b orphan=%b res_valid=%b err=%0d expected 1 1 0 %0d", ok, orphan_o, res_valid_o, err_cnt_o, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) issue(OP_WRITE, KW'(i + 1), DW'(i), ok);
    step();
    req_ready_i = 1'b0;
    res_ready_i = 1'b0;
    respond(32'h0, ok);
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pending: res_valid=%b expected 1", res_valid_o);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (req_valid_o !== 1'b0 || res_valid_o !== 1'b0 || issued_cnt_o !== '0 || err_cnt_o !== '0 || orphan_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: req_valid=%b res_valid=%b issued=%0d err=%0d orphan=%b expected all 0", req_valid_o, res_valid_o, issued_cnt_o, err_cnt_o, orphan_o);
    end
    req_q.delete();
    res_q.delete();
    exp_issued = 0;
    exp_err = 0;
    step();
    reset = 1'b1;
    step();
    respond(32'h0, ok);
    exp_err++;
    checks++;
    if (!ok || orphan_o !== 1'b1 || res_valid_o !== 1'b0 || err_cnt_o !== CW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL stale_orphan: accepted=%b orphan=%b res_valid=%b err=%0d expected 1 1 0 %0d", ok, orphan_o, res_valid_o, err_cnt_o, exp_err);
    end
  endtask

  initial begin
    reset = 1'b0;
    host_valid_i = 1'b0; host_op_i = '0; host_key_i = '0; host_data_i = '0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0; res_ready_i = 1'b0;
    #2;
    test_reset();
    test_write_ok();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_proto_err();
    test_illegal_op();
    test_orphan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
